// File: rtl/snake_dir_scheduler.sv
// Snake direction scheduler: parses PS/2 make/break/extended scancodes, queues legal
// direction changes and releases one per game_tick; also decodes restart and pause keys.
module snake_dir_scheduler #(
  parameter int          QDEPTH      = 4,
  parameter logic [3:0]  INIT_DIR    = 4'b1000,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ps2_code,
  input  logic                      ps2_valid,
  input  logic                      game_tick,
  output logic [3:0]                direction,
  output logic                      dir_changed,
  output logic                      rst_game,
  output logic                      paused,
  output logic [$clog2(QDEPTH):0]   q_level,
  output logic                      overflow
);

  localparam int AW = $clog2(QDEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(QDEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXT_BRK} pstate_t;

  // Up<->down and left<->right are two bit positions apart in the one-hot encoding.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[1:0], d[3:2]};
  endfunction

  pstate_t         state_r, state_s;
  logic [CW-1:0]   tmo_r, tmo_s;
  logic            dir_act_s, restart_s, pause_s;
  logic [3:0]      cmd_s;
  logic [3:0]      fifo_r [QDEPTH];
  logic [AW-1:0]   head_r, tail_r;
  logic [3:0]      ref_s;
  logic            pop_s, full_s, legal_s, push_s, drop_s;

  // Parser next-state, timeout counter and decoded key actions.
  always_comb begin
    state_s   = state_r;
    tmo_s     = tmo_r;
    dir_act_s = 1'b0;
    restart_s = 1'b0;
    pause_s   = 1'b0;
    cmd_s     = 4'b0000;
    if (ps2_valid) begin
      tmo_s = '0;
      case (state_r)
        P_IDLE: begin
          case (ps2_code)
            8'hF0:   state_s = P_BRK;
            8'hE0:   state_s = P_EXT;
            8'h1D:   begin dir_act_s = 1'b1; cmd_s = 4'b0001; end
            8'h1C:   begin dir_act_s = 1'b1; cmd_s = 4'b0010; end
            8'h1B:   begin dir_act_s = 1'b1; cmd_s = 4'b0100; end
            8'h23:   begin dir_act_s = 1'b1; cmd_s = 4'b1000; end
            8'h2D:   restart_s = 1'b1;
            8'h4D:   pause_s = 1'b1;
            default: state_s = P_IDLE;
          endcase
        end
        P_EXT: begin
          state_s = P_IDLE;
          case (ps2_code)
            8'hF0:   state_s = P_EXT_BRK;
            8'h75:   begin dir_act_s = 1'b1; cmd_s = 4'b0001; end
            8'h6B:   begin dir_act_s = 1'b1; cmd_s = 4'b0010; end
            8'h72:   begin dir_act_s = 1'b1; cmd_s = 4'b0100; end
            8'h74:   begin dir_act_s = 1'b1; cmd_s = 4'b1000; end
            default: state_s = P_IDLE;
          endcase
        end
        default: state_s = P_IDLE;
      endcase
    end else if (state_r != P_IDLE) begin
      if (tmo_r == TMO_LAST) begin
        state_s = P_IDLE;
        tmo_s   = '0;
      end else begin
        tmo_s = tmo_r + CW'(1);
      end
    end else begin
      tmo_s = '0;
    end
  end

  // Enqueue/dequeue decisions; a new command is compared against the newest queued one.
  always_comb begin
    ref_s   = (q_level != '0) ? fifo_r[tail_r - PTR_ONE] : direction;
    pop_s   = game_tick && !paused && (q_level != '0) && !restart_s;
    full_s  = (q_level == LVL_FULL);
    legal_s = dir_act_s && (cmd_s != ref_s) && (cmd_s != opposite(ref_s));
    push_s  = legal_s && !restart_s && (!full_s || pop_s);
    drop_s  = legal_s && full_s && !pop_s;
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= P_IDLE;
      tmo_r   <= '0;
    end else begin
      state_r <= state_s;
      tmo_r   <= tmo_s;
    end
  end

  // FIFO storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[tail_r] <= cmd_s;
    end else begin
      fifo_r[tail_r] <= fifo_r[tail_r];
    end
  end

  // Queue pointers, direction and status outputs.
  always_ff @(posedge clk) begin
    if (!rst || restart_s) begin
      head_r      <= '0;
      tail_r      <= '0;
      q_level     <= '0;
      direction   <= INIT_DIR;
      dir_changed <= 1'b0;
      paused      <= 1'b0;
      overflow    <= 1'b0;
      rst_game    <= rst ? restart_s : 1'b0;
    end else begin
      rst_game    <= 1'b0;
      dir_changed <= pop_s;
      paused      <= paused ^ pause_s;
      overflow    <= overflow | drop_s;
      if (push_s) tail_r <= tail_r + PTR_ONE;
      else        tail_r <= tail_r;
      if (pop_s) begin
        head_r    <= head_r + PTR_ONE;
        direction <= fifo_r[head_r];
      end else begin
        head_r    <= head_r;
        direction <= direction;
      end
      case ({push_s, pop_s})
        2'b10:   q_level <= q_level + LVL_ONE;
        2'b01:   q_level <= q_level - LVL_ONE;
        default: q_level <= q_level;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Directed self-checking bench for snake_dir_scheduler (QDEPTH=4, short timeout).
module tb_snake_dir_scheduler;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ps2_code = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       game_tick = 1'b0;
  logic [3:0] direction;
  logic       dir_changed, rst_game, paused, overflow;
  logic [2:0] q_level;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  snake_dir_scheduler #(.QDEPTH(4), .INIT_DIR(4'b1000), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_code(ps2_code), .ps2_valid(ps2_valid),
    .game_tick(game_tick), .direction(direction), .dir_changed(dir_changed),
    .rst_game(rst_game), .paused(paused), .q_level(q_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte (optionally with a tick); outputs are checked at the negedge after.
  task automatic step(input logic [7:0] code, input logic v, input logic t);
    @(negedge clk);
    ps2_code  = code;
    ps2_valid = v;
    game_tick = t;
    @(negedge clk);
    ps2_valid = 1'b0;
    game_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] code);
    step(code, 1'b1, 1'b0);
  endtask

  task automatic tick();
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic fill4();
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dir", 8'(direction), 8'h08);
    chk("rst_q", 8'(q_level), 8'h00);
    chk("rst_paused", 8'(paused), 8'h00);
    chk("rst_ovf", 8'(overflow), 8'h00);
    chk("rst_chg", 8'(dir_changed), 8'h00);
    chk("rst_game0", 8'(rst_game), 8'h00);

    // W then tick
    send(8'h1D);
    chk("t1_q", 8'(q_level), 8'h01);
    chk("t1_dir_before", 8'(direction), 8'h08);
    tick();
    chk("t1_dir", 8'(direction), 8'h01);
    chk("t1_chg", 8'(dir_changed), 8'h01);
    chk("t1_q0", 8'(q_level), 8'h00);
    @(negedge clk);
    chk("t1_chg_once", 8'(dir_changed), 8'h00);
    tick();
    chk("empty_tick_dir", 8'(direction), 8'h01);
    chk("empty_tick_chg", 8'(dir_changed), 8'h00);

    // restart back to right, reversal dropped, two queued moves
    send(8'h2D);
    chk("t2_rstgame", 8'(rst_game), 8'h01);
    chk("t2_dir", 8'(direction), 8'h08);
    @(negedge clk);
    chk("t2_rstgame_once", 8'(rst_game), 8'h00);
    send(8'h1C);
    chk("t2_reversal", 8'(q_level), 8'h00);
    send(8'h1D); send(8'h1D);
    chk("t2_repeat", 8'(q_level), 8'h01);
    send(8'h1C);
    chk("t2_q2", 8'(q_level), 8'h02);
    tick();
    chk("t2_pop1", 8'(direction), 8'h01);
    tick();
    chk("t2_pop2", 8'(direction), 8'h02);
    chk("t2_q0", 8'(q_level), 8'h00);

    // extended and break sequences (direction is left)
    send(8'hE0); send(8'h75);
    chk("t3_ext_up", 8'(q_level), 8'h01);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("t3_ext_brk", 8'(q_level), 8'h01);
    send(8'hF0); send(8'h1C);
    chk("t3_brk", 8'(q_level), 8'h01);
    tick();
    chk("t3_dir", 8'(direction), 8'h01);

    // fill FIFO and overflow
    send(8'h2D);
    fill4();
    chk("t4_full", 8'(q_level), 8'h04);
    chk("t4_no_ovf", 8'(overflow), 8'h00);
    send(8'h1D);
    chk("t4_ovf", 8'(overflow), 8'h01);
    chk("t4_q4", 8'(q_level), 8'h04);
    send(8'h2D);
    chk("t4_rst_ovf", 8'(overflow), 8'h00);
    fill4();
    step(8'h1D, 1'b1, 1'b1);
    chk("t4_pp_q", 8'(q_level), 8'h04);
    chk("t4_pp_ovf", 8'(overflow), 8'h00);
    chk("t4_pp_dir", 8'(direction), 8'h01);
    tick();
    chk("t4_d2", 8'(direction), 8'h02);
    tick();
    chk("t4_d3", 8'(direction), 8'h04);
    tick();
    chk("t4_d4", 8'(direction), 8'h08);
    tick();
    chk("t4_wrap", 8'(direction), 8'h01);
    chk("t4_drained", 8'(q_level), 8'h00);

    // parser timeout
    send(8'h2D);
    send(8'hE0);
    repeat (5) @(negedge clk);
    send(8'h1D);
    chk("t5_still_ext", 8'(q_level), 8'h00);
    send(8'hE0);
    repeat (TMO) @(negedge clk);
    send(8'h1D);
    chk("t5_timeout", 8'(q_level), 8'h01);

    // pause then restart
    send(8'h4D);
    chk("t6_paused", 8'(paused), 8'h01);
    tick();
    chk("t6_nochg_dir", 8'(direction), 8'h08);
    chk("t6_nochg_pulse", 8'(dir_changed), 8'h00);
    chk("t6_nochg_q", 8'(q_level), 8'h01);
    send(8'h1C);
    chk("t6_q_paused", 8'(q_level), 8'h02);
    send(8'h2D);
    chk("t6_rstgame", 8'(rst_game), 8'h01);
    chk("t6_dir", 8'(direction), 8'h08);
    chk("t6_q", 8'(q_level), 8'h00);
    chk("t6_unpaused", 8'(paused), 8'h00);

    // reset mid-sequence
    send(8'h1D); send(8'h4D); send(8'hE0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t7_q", 8'(q_level), 8'h00);
    chk("t7_paused", 8'(paused), 8'h00);
    send(8'h75);
    chk("t7_idle_parse", 8'(q_level), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
